// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Optional build macro: MULDIV_EARLY_OUT_EN (multiply early termination).
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIX,
      ST_DONE
   } state_e;

   function automatic logic is_arith(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_signed(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Purely combinational; the caller registers the results.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               div_mode,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [2*WIDTH-1:0] opa,
   input  logic [WIDTH-1:0]   opb,
   output logic [2*WIDTH-1:0] acc_next,
   output logic [2*WIDTH-1:0] opa_next,
   output logic [WIDTH-1:0]   opb_next
);

   logic [WIDTH:0] rem_shift;
   logic           fits;

   // Divide keeps {remainder, dividend/quotient} in acc and the divisor in opb.
   assign rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign fits      = (rem_shift >= {1'b0, opb});

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      acc_next = acc;
      opa_next = opa;
      opb_next = opb;
      if (div_mode) begin
         if (fits) begin
            acc_next = {rem_shift[WIDTH-1:0] - opb, acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (opb[0]) begin
            acc_next = acc + opa;
         end
         opa_next = opa << 1;
         opb_next = opb >> 1;
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers and MTHI/MTLO.
// Optional build macro: MULDIV_EARLY_OUT_EN (multiply leaves RUN once the multiplier is exhausted).
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] RSdata_i,
   input  logic [WIDTH-1:0] RTdata_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] HI_o,
   output logic [WIDTH-1:0] LO_o
);

   import muldiv_pkg::*;

   localparam int CW = $clog2(WIDTH);

   state_e             state, state_d;
   logic [2*WIDTH-1:0] acc, opa, acc_next, opa_next;
   logic [WIDTH-1:0]   opb, opb_next;
   logic [CW-1:0]      cnt;
   logic               div_q, neg_res, neg_rem, div_zero;
   logic               load, step, fix, mthi_we, mtlo_we, last_step;

   logic               sign_a, sign_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot, rem, fix_hi, fix_lo;

   assign sign_a = is_signed(op_i) & RSdata_i[WIDTH-1];
   assign sign_b = is_signed(op_i) & RTdata_i[WIDTH-1];
   assign mag_a  = sign_a ? -RSdata_i : RSdata_i;
   assign mag_b  = sign_b ? -RTdata_i : RTdata_i;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .div_mode (div_q),
      .acc      (acc),
      .opa      (opa),
      .opb      (opb),
      .acc_next (acc_next),
      .opa_next (opa_next),
      .opb_next (opb_next)
   );

   always_comb begin
      last_step = (cnt == CW'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
      if (!div_q && (opb_next == '0)) begin
         last_step = 1'b1;
      end
`endif
   end

   // Flush wins over everything, including a start presented in the same cycle.
   always_comb begin
      state_d = state;
      load    = 1'b0;
      step    = 1'b0;
      fix     = 1'b0;
      mthi_we = 1'b0;
      mtlo_we = 1'b0;
      if (flush_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               state_d = ST_IDLE;
               if (start_i) begin
                  if (is_arith(op_i)) begin
                     load    = 1'b1;
                     state_d = ST_RUN;
                  end else if (op_i == OP_MTHI) begin
                     mthi_we = 1'b1;
                  end else if (op_i == OP_MTLO) begin
                     mtlo_we = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               step = 1'b1;
               if (last_step) begin
                  state_d = ST_FIX;
               end
            end
            ST_FIX: begin
               fix     = 1'b1;
               state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // NOTE: datapath registers are reset too, so a reset mid-operation leaves no stale operands.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc      <= '0;
         opa      <= '0;
         opb      <= '0;
         cnt      <= '0;
         div_q    <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
      end else if (load) begin
         div_q    <= is_div(op_i);
         neg_res  <= sign_a ^ sign_b;
         neg_rem  <= sign_a & is_div(op_i);
         div_zero <= (RTdata_i == '0);
         cnt      <= '0;
         opb      <= mag_b;
         if (is_div(op_i)) begin
            acc <= {{WIDTH{1'b0}}, mag_a};
            opa <= '0;
         end else begin
            acc <= '0;
            opa <= {{WIDTH{1'b0}}, mag_a};
         end
      end else if (step) begin
         acc <= acc_next;
         opa <= opa_next;
         opb <= opb_next;
         cnt <= cnt + 1'b1;
      end
   end

   // Divide by zero keeps the all-ones quotient; the remainder sign fix restores the original dividend.
   always_comb begin
      prod = neg_res ? -acc : acc;
      quot = acc[WIDTH-1:0];
      rem  = acc[2*WIDTH-1:WIDTH];
      if (div_q) begin
         fix_hi = neg_rem ? -rem : rem;
         fix_lo = (neg_res && !div_zero) ? -quot : quot;
      end else begin
         fix_hi = prod[2*WIDTH-1:WIDTH];
         fix_lo = prod[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         HI_o <= '0;
         LO_o <= '0;
      end else if (fix) begin
         HI_o <= fix_hi;
         LO_o <= fix_lo;
      end else begin
         if (mthi_we) HI_o <= RSdata_i;
         if (mtlo_we) LO_o <= RSdata_i;
      end
   end

   assign busy_o = (state == ST_RUN) || (state == ST_FIX);
   assign done_o = (state == ST_DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random operations
// checked against an arithmetic reference model.
module tb_mul_div_unit;

   localparam int W = 32;

   logic          clk_i = 1'b0;
   logic          rst_n_i = 1'b1;
   logic          start_i = 1'b0;
   logic [2:0]    op_i = 3'd0;
   logic [W-1:0]  RSdata_i = '0;
   logic [W-1:0]  RTdata_i = '0;
   logic          flush_i = 1'b0;
   logic          busy_o, done_o;
   logic [W-1:0]  HI_o, LO_o;

   int checks = 0;
   int errors = 0;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .start_i  (start_i),
      .op_i     (op_i),
      .RSdata_i (RSdata_i),
      .RTdata_i (RTdata_i),
      .flush_i  (flush_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .HI_o     (HI_o),
      .LO_o     (LO_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
      $fatal(1, "watchdog");
   end

   // Reference: plain integer arithmetic following the MIPS HI/LO rules.
   function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
      longint sa, sb, p;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      hi = '0;
      lo = '0;
      case (op)
         3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
         3'd1: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
         3'd2: begin
            if (b == 0) begin hi = a; lo = '1; end
            else begin p = sa / sb; lo = p[31:0]; p = sa % sb; hi = p[31:0]; end
         end
         3'd3: begin
            if (b == 0) begin hi = a; lo = '1; end
            else begin lo = a / b; hi = a % b; end
         end
         default: ;
      endcase
   endfunction

   // Cycles from the start edge until done_o is seen (done cycle counted).
   function automatic int exp_latency(input logic [2:0] op, input logic [31:0] b);
      int runs;
      logic [31:0] mag;
      runs = 32;
`ifdef MULDIV_EARLY_OUT_EN
      if (op <= 3'd1) begin
         mag = (op == 3'd0 && b[31]) ? -b : b;
         runs = 1;
         for (int i = 0; i < 32; i++) if (mag[i]) runs = i + 1;
      end
`else
      mag = b;
      if (op > 3'd7 && mag == 0) runs = 0;
`endif
      return runs + 2;
   endfunction

   function automatic logic [31:0] rand_operand();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0: v = 32'h0;
         1: v = 32'hFFFF_FFFF;
         2: v = 32'h8000_0000;
         3: begin v = $urandom_range(1, 20); if ($urandom_range(0, 1) == 1) v = -v; end
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Starts an operation at the current negedge and returns at the negedge where done_o is high.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int lat, output logic busy_bad);
      start_i  = 1'b1;
      op_i     = op;
      RSdata_i = a;
      RTdata_i = b;
      @(negedge clk_i);
      start_i  = 1'b0;
      RSdata_i = $urandom;
      RTdata_i = $urandom;
      lat      = 1;
      busy_bad = 1'b0;
      while (done_o !== 1'b1 && lat < 100) begin
         if (busy_o !== 1'b1) busy_bad = 1'b1;
         @(negedge clk_i);
         lat++;
      end
      if (busy_o !== 1'b0) busy_bad = 1'b1;
      hi = HI_o;
      lo = LO_o;
   endtask

   task automatic test_reset();
      #2 rst_n_i = 1'b0;
      #1;
      checks++;
      if ({busy_o, done_o, HI_o, LO_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b hi=%h lo=%h, want all zero", busy_o, done_o, HI_o, LO_o);
      end
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if ({busy_o, done_o} !== 2'b00) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy_o, done_o);
      end
   endtask

   task automatic test_directed();
      logic [2:0]  t_op [10] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd0, 3'd2, 3'd3, 3'd2, 3'd0};
      logic [31:0] t_a  [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000,
                                 32'd5, 32'hFFFF_FFF9, 32'd9, 32'd7, 32'h8000_0000};
      logic [31:0] t_b  [10] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF,
                                 32'd1, 32'd0, 32'd4, 32'hFFFF_FFFE, 32'h8000_0000};
      logic [31:0] t_hi [10] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'h0,
                                 32'h0, 32'hFFFF_FFF9, 32'd1, 32'd1, 32'h4000_0000};
      logic [31:0] t_lo [10] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000,
                                 32'd5, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFD, 32'h0};
      logic [31:0] hi, lo;
      logic        busy_bad;
      int          lat;
      for (int i = 0; i < 10; i++) begin
         do_op(t_op[i], t_a[i], t_b[i], hi, lo, lat, busy_bad);
         checks++;
         if ({hi, lo} !== {t_hi[i], t_lo[i]}) begin
            errors++;
            $display("FAIL directed_result[%0d]: got hi=%h lo=%h, want hi=%h lo=%h", i, hi, lo, t_hi[i], t_lo[i]);
         end
         checks++;
         if (lat !== exp_latency(t_op[i], t_b[i])) begin
            errors++;
            $display("FAIL directed_latency[%0d]: got %0d cycles, want %0d", i, lat, exp_latency(t_op[i], t_b[i]));
         end
         checks++;
         if (busy_bad !== 1'b0) begin
            errors++;
            $display("FAIL directed_busy[%0d]: busy_o wrong while running or at done, got flag %b want 0", i, busy_bad);
         end
      end
      @(negedge clk_i);
      checks++;
      if ({done_o, busy_o} !== 2'b00) begin
         errors++;
         $display("FAIL done_pulse_width: got done=%b busy=%b one cycle after done, want 0 0", done_o, busy_o);
      end
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b, hi, lo, ehi, elo;
      logic        busy_bad;
      int          lat;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 3));
         a  = rand_operand();
         b  = rand_operand();
         ref_model(op, a, b, ehi, elo);
         do_op(op, a, b, hi, lo, lat, busy_bad);
         checks++;
         if ({hi, lo} !== {ehi, elo} || lat !== exp_latency(op, b) || busy_bad !== 1'b0) begin
            errors++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h lat=%0d busybad=%b, want hi=%h lo=%h lat=%0d busybad=0",
                     i, op, a, b, hi, lo, lat, busy_bad, ehi, elo, exp_latency(op, b));
         end
         if ($urandom_range(0, 3) == 0) @(negedge clk_i);
      end
      @(negedge clk_i);
   endtask

   task automatic test_mthi_mtlo();
      start_i  = 1'b1;
      op_i     = 3'd4;
      RSdata_i = 32'h1234_5678;
      @(negedge clk_i);
      checks++;
      if ({HI_o, busy_o, done_o} !== {32'h1234_5678, 2'b00}) begin
         errors++;
         $display("FAIL mthi: got hi=%h busy=%b done=%b, want hi=12345678 busy=0 done=0", HI_o, busy_o, done_o);
      end
      op_i     = 3'd5;
      RSdata_i = 32'h9ABC_DEF0;
      @(negedge clk_i);
      start_i = 1'b0;
      checks++;
      if ({HI_o, LO_o, busy_o, done_o} !== {32'h1234_5678, 32'h9ABC_DEF0, 2'b00}) begin
         errors++;
         $display("FAIL mtlo: got hi=%h lo=%h busy=%b done=%b, want hi=12345678 lo=9abcdef0 busy=0 done=0",
                  HI_o, LO_o, busy_o, done_o);
      end
   endtask

   task automatic test_reserved_op();
      logic [31:0] hi0, lo0;
      logic        seen;
      hi0 = HI_o;
      lo0 = LO_o;
      seen = 1'b0;
      for (int k = 6; k < 8; k++) begin
         start_i  = 1'b1;
         op_i     = 3'(k);
         RSdata_i = 32'hCAFE_0000 + k;
         RTdata_i = 32'd3;
         @(negedge clk_i);
         start_i = 1'b0;
         repeat (3) begin
            if (busy_o !== 1'b0 || done_o !== 1'b0) seen = 1'b1;
            @(negedge clk_i);
         end
      end
      checks++;
      if ({seen, HI_o, LO_o} !== {1'b0, hi0, lo0}) begin
         errors++;
         $display("FAIL reserved_op: got activity=%b hi=%h lo=%h, want activity=0 hi=%h lo=%h", seen, HI_o, LO_o, hi0, lo0);
      end
   endtask

   task automatic test_flush();
      logic [31:0] hi0, lo0;
      logic        seen;
      hi0 = HI_o;
      lo0 = LO_o;
      start_i  = 1'b1;
      op_i     = 3'd1;
      RSdata_i = 32'hFFFF_FFFF;
      RTdata_i = 32'hFFFF_FFFF;
      @(negedge clk_i);
      start_i = 1'b0;
      for (int cyc = 1; cyc < 10; cyc++) begin
         start_i  = (cyc == 5);
         op_i     = 3'd4;
         RSdata_i = 32'hDEAD_BEEF;
         @(negedge clk_i);
      end
      start_i = 1'b0;
      checks++;
      if ({busy_o, HI_o} !== {1'b1, hi0}) begin
         errors++;
         $display("FAIL start_while_busy: got busy=%b hi=%h, want busy=1 hi=%h", busy_o, HI_o, hi0);
      end
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_to_idle: got busy=%b, want 0", busy_o);
      end
      seen = 1'b0;
      repeat (40) begin
         if (done_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
         @(negedge clk_i);
      end
      checks++;
      if ({seen, HI_o, LO_o} !== {1'b0, hi0, lo0}) begin
         errors++;
         $display("FAIL flush_no_done: got activity=%b hi=%h lo=%h, want activity=0 hi=%h lo=%h", seen, HI_o, LO_o, hi0, lo0);
      end
      flush_i  = 1'b1;
      start_i  = 1'b1;
      op_i     = 3'd5;
      RSdata_i = 32'h0BAD_F00D;
      @(negedge clk_i);
      flush_i = 1'b0;
      start_i = 1'b0;
      checks++;
      if (LO_o !== lo0) begin
         errors++;
         $display("FAIL flush_priority: got lo=%h, want %h", LO_o, lo0);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] hi, lo;
      logic        busy_bad;
      int          lat;
      start_i  = 1'b1;
      op_i     = 3'd3;
      RSdata_i = 32'hFFFF_0000;
      RTdata_i = 32'd77;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (8) @(negedge clk_i);
      @(posedge clk_i);
      #2 rst_n_i = 1'b0;
      #1;
      checks++;
      if ({busy_o, done_o, HI_o, LO_o} !== '0) begin
         errors++;
         $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h, want all zero", busy_o, done_o, HI_o, LO_o);
      end
      #23 rst_n_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if ({busy_o, done_o} !== 2'b00) begin
         errors++;
         $display("FAIL reset_release_idle: got busy=%b done=%b, want 0 0", busy_o, done_o);
      end
      do_op(3'd3, 32'd9, 32'd4, hi, lo, lat, busy_bad);
      checks++;
      if ({hi, lo, lat} !== {32'd1, 32'd2, 34}) begin
         errors++;
         $display("FAIL divu_after_reset: got hi=%h lo=%h lat=%0d, want hi=1 lo=2 lat=34", hi, lo, lat);
      end
      @(negedge clk_i);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mthi_mtlo();
      test_reserved_op();
      test_random();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
